rom_port_arbiter: RTL and testbench
===================================

ROM_PORT_ARBITER -- requirements
Module: rom_port_arbiter

Interface
REQ-001 Parameter CPU_BASE, 22'h0, word offset added to the CPU word address on the memory port.
REQ-002 Parameter DL_OFFSET, 25'h0, byte offset subtracted from ioctl_addr before mapping to memory.
REQ-003 clk_sys  in  1  single clock; all logic on its rising edge.
REQ-004 reset_n  in  1  reset, synchronous, active-low.
REQ-005 ioctl_downl  in  1  download active.
REQ-006 ioctl_wr  in  1  download byte strobe, level, one or more cycles.
REQ-007 ioctl_addr  in  25  download byte address.
REQ-008 ioctl_dout  in  8  download byte.
REQ-009 cpu_rd  in  1  one-cycle ROM read request.
REQ-010 cpu_addr  in  16  CPU byte address, sampled with cpu_rd.
REQ-011 cpu_dout  out  8  read byte, held until the next read completes.
REQ-012 cpu_valid  out  1  one-cycle pulse, cpu_dout valid.
REQ-013 mem_req  out  1  toggle request to the SDRAM port.
REQ-014 mem_ack  in  1  toggle acknowledge; transfer done when mem_ack == mem_req.
REQ-015 mem_we, mem_addr[21:0], mem_ds[1:0], mem_din[15:0]  out  memory command, stable while a request is outstanding.
REQ-016 mem_dout  in  16  read word, valid in the cycle mem_ack matches mem_req.
REQ-017 rom_loaded  out  1  set on the falling edge of ioctl_downl, sticky.
REQ-018 dl_overrun  out  1  sticky; a download byte was dropped.

Function
REQ-019 FSM states: IDLE, WR_WAIT, RD_WAIT; one outstanding memory request maximum.
REQ-020 Byte capture on the ioctl_wr rising edge with ioctl_downl=1 goes to a one-entry pending buffer; a capture while the buffer is full sets dl_overrun and drops the byte.
REQ-021 Write mapping: a = ioctl_addr - DL_OFFSET; mem_addr = a[22:1]; mem_ds = {a[0], ~a[0]}; mem_din = {byte, byte}; mem_we = 1.
REQ-022 Read mapping: mem_addr = CPU_BASE + cpu_addr[15:1]; mem_we = 0; mem_ds = 2'b11.
REQ-023 In IDLE, a pending write has priority over a read; issue = drive the command and toggle mem_req in the same cycle; move to WR_WAIT or RD_WAIT.
REQ-024 WR_WAIT/RD_WAIT: return to IDLE in the cycle mem_ack == mem_req.
REQ-025 RD_WAIT completion: store the word and its address in a one-word cache; set cpu_dout = cpu_addr[0] ? mem_dout[15:8] : mem_dout[7:0]; pulse cpu_valid.
REQ-026 Cache hit (valid, same word address, ioctl_downl=0): cpu_valid the cycle after cpu_rd, with no memory access.
REQ-027 cpu_rd while ioctl_downl=1 is ignored, with no cpu_valid.
REQ-028 Any ioctl_wr capture invalidates the cache.
REQ-029 cpu_rd while busy: latch it (one entry) and serve it after the current transfer; further cpu_rd calls while latched overwrite the latched one.
REQ-030 Simultaneous capture and cpu_rd in IDLE: the write is issued first.

Reset
REQ-031 On reset_n=0 at a clock edge: state=IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_ds=0, mem_din=0, cpu_dout=0, cpu_valid=0, rom_loaded=0, dl_overrun=0, buffers/cache invalid.
REQ-032 After reset mid-transfer, mem_req=0; the first request waits until mem_ack=0 (idle match) before issuing.

Configuration
REQ-033 ROM_WRITE_COMBINE_EN defined: an even-address byte is held; the following odd byte at a+1 issues one write with mem_ds=2'b11 and mem_din={odd, even}; a non-consecutive byte or the ioctl_downl falling edge flushes the held byte as a single-byte write first.
REQ-034 ROM_WRITE_COMBINE_EN undefined: one write per byte per REQ-021.

Structure
REQ-035 Package rom_arb_pkg: FSM state enum, address width constants (MEM_AW=22, DL_AW=25).
REQ-036 No sub-module; the pending-write buffer stays inline.

Verification
REQ-037 Download of bytes 0x11,0x22 to addresses 0,1 (no combine): two writes, mem_addr=0, mem_ds=01 then 10; with combine: one write, mem_din=16'h2211, ds=11.
REQ-038 ioctl_wr edges 2 cycles apart with mem_ack delayed 10 cycles: dl_overrun=1 on the third byte.
REQ-039 cpu_rd addr 0x0003, mem_dout=16'hABCD after 5 cycles: cpu_dout=0xAB, cpu_valid one pulse; repeat read at 0x0002 gives 0xCD one cycle later, no mem_req toggle.
REQ-040 cpu_rd during ioctl_downl=1: no mem request, no cpu_valid; falling edge of ioctl_downl: rom_loaded=1.
REQ-041 reset_n low during RD_WAIT: all outputs reach reset values on the next edge; no cpu_valid afterwards for that read.

Source files
------------

// File: rtl/rom_arb_pkg.sv
// ============================================================================
// Module      : rom_arb_pkg
// Description : Shared types and widths for the ROM port arbiter.
//               MEM_AW - SDRAM word-address width
//               DL_AW  - download byte-address width
//               arb_state_t - arbiter FSM states
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rom_arb_pkg;

  localparam int MEM_AW = 22;
  localparam int DL_AW  = 25;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WR_WAIT = 2'd1,
    RD_WAIT = 2'd2
  } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/rom_port_arbiter.sv
// ============================================================================
// Module      : rom_port_arbiter
// Description : Shares one toggle-handshake SDRAM port between a ROM download
//               stream (byte writes) and CPU ROM byte reads, with a one-entry
//               pending write buffer, a one-entry latched CPU read and a
//               one-word read cache.
// Ports       : clk_sys, reset_n (sync, active-low)
//               ioctl_downl/ioctl_wr/ioctl_addr/ioctl_dout - download stream
//               cpu_rd/cpu_addr in, cpu_dout/cpu_valid out - CPU read port
//               mem_req/mem_ack toggle handshake, mem_we/mem_addr/mem_ds/
//               mem_din command, mem_dout read word - SDRAM port
//               rom_loaded, dl_overrun - sticky status
// Options     : ROM_WRITE_COMBINE_EN - merge an even byte with the following
//               odd byte into one 16-bit write.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rom_port_arbiter
  import rom_arb_pkg::*;
#(
  parameter logic [MEM_AW-1:0] CPU_BASE  = 22'h0,
  parameter logic [DL_AW-1:0]  DL_OFFSET = 25'h0
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              ioctl_downl,
  input  logic              ioctl_wr,
  input  logic [DL_AW-1:0]  ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  input  logic              cpu_rd,
  input  logic [15:0]       cpu_addr,
  output logic [7:0]        cpu_dout,
  output logic              cpu_valid,
  output logic              mem_req,
  input  logic              mem_ack,
  output logic              mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [1:0]        mem_ds,
  output logic [15:0]       mem_din,
  input  logic [15:0]       mem_dout,
  output logic              rom_loaded,
  output logic              dl_overrun
);

  arb_state_t state, state_nxt;

  logic              wr_d, downl_d;
  logic              capture, downl_fall, mem_idle;
  logic [DL_AW-1:0]  dl_a;
  logic              unused_dl_hi;

  // pending write buffer
  logic              pend_valid, pend_free;
  logic [MEM_AW-1:0] pend_addr;
  logic [1:0]        pend_ds;
  logic [15:0]       pend_din;
  logic              push, ovr;
  logic [MEM_AW-1:0] push_addr;
  logic [1:0]        push_ds;
  logic [15:0]       push_din;

  // CPU read latch, in-flight read and cache
  logic              rd_pend, rd_new, rd_req, rd_hit;
  logic [15:0]       rd_addr, rd_addr_sel, cur_addr;
  logic              cache_valid, stale;
  logic [14:0]       cache_waddr;
  logic [15:0]       cache_word;

  logic              issue_wr, issue_rd, serve_hit, rd_done;

  assign capture      = ioctl_wr & ~wr_d & ioctl_downl;
  assign downl_fall   = downl_d & ~ioctl_downl;
  assign dl_a         = ioctl_addr - DL_OFFSET;
  assign unused_dl_hi = ^dl_a[DL_AW-1:MEM_AW+1];
  assign mem_idle     = (mem_ack == mem_req);
  assign pend_free    = ~pend_valid | issue_wr;

  // A new cpu_rd overrides the latched one; both are served via rd_addr_sel.
  assign rd_new      = cpu_rd & ~ioctl_downl;
  assign rd_req      = rd_new | rd_pend;
  assign rd_addr_sel = rd_new ? cpu_addr : rd_addr;
  assign rd_hit      = cache_valid & ~ioctl_downl & (cache_waddr == rd_addr_sel[15:1]);

`ifdef ROM_WRITE_COMBINE_EN
  logic             held_valid, hold_load, hold_clr;
  logic [DL_AW-1:0] held_a;
  logic [7:0]       held_byte;

  // The held slot keeps one byte back; it is merged with the next byte when
  // that byte is its odd partner, otherwise it is flushed as a single write.
  always_comb begin
    push      = 1'b0;
    ovr       = 1'b0;
    hold_load = 1'b0;
    hold_clr  = 1'b0;
    push_addr = held_a[MEM_AW:1];
    push_ds   = {held_a[0], ~held_a[0]};
    push_din  = {held_byte, held_byte};
    if (capture) begin
      if (held_valid && !held_a[0] && (dl_a == held_a + DL_AW'(1))) begin
        if (pend_free) begin
          push     = 1'b1;
          push_ds  = 2'b11;
          push_din = {ioctl_dout, held_byte};
          hold_clr = 1'b1;
        end else begin
          ovr = 1'b1;
        end
      end else if (held_valid) begin
        if (pend_free) begin
          push      = 1'b1;
          hold_load = 1'b1;
        end else begin
          ovr = 1'b1;
        end
      end else if (!dl_a[0]) begin
        hold_load = 1'b1;
      end else if (pend_free) begin
        push      = 1'b1;
        push_addr = dl_a[MEM_AW:1];
        push_ds   = 2'b10;
        push_din  = {ioctl_dout, ioctl_dout};
      end else begin
        ovr = 1'b1;
      end
    end else if (held_valid && !ioctl_downl && pend_free) begin
      // download ended with a byte still held
      push     = 1'b1;
      hold_clr = 1'b1;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      held_valid <= 1'b0;
      held_a     <= '0;
      held_byte  <= '0;
    end else if (hold_load) begin
      held_valid <= 1'b1;
      held_a     <= dl_a;
      held_byte  <= ioctl_dout;
    end else if (hold_clr) begin
      held_valid <= 1'b0;
    end
  end
`else
  always_comb begin
    push      = capture & pend_free;
    ovr       = capture & ~pend_free;
    push_addr = dl_a[MEM_AW:1];
    push_ds   = {dl_a[0], ~dl_a[0]};
    push_din  = {ioctl_dout, ioctl_dout};
  end
`endif

  always_ff @(posedge clk_sys) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // A capture in the same cycle as a read defers the read so the freshly
  // captured byte reaches memory first.
  always_comb begin
    state_nxt = state;
    issue_wr  = 1'b0;
    issue_rd  = 1'b0;
    serve_hit = 1'b0;
    rd_done   = 1'b0;
    case (state)
      IDLE: begin
        if (pend_valid) begin
          if (mem_idle) begin
            issue_wr  = 1'b1;
            state_nxt = WR_WAIT;
          end
        end else if (rd_req && !capture) begin
          if (rd_hit) begin
            serve_hit = 1'b1;
          end else if (mem_idle) begin
            issue_rd  = 1'b1;
            state_nxt = RD_WAIT;
          end
        end
      end
      WR_WAIT: if (mem_idle) state_nxt = IDLE;
      RD_WAIT: begin
        if (mem_idle) begin
          rd_done   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      wr_d        <= 1'b0;
      downl_d     <= 1'b0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_ds      <= '0;
      mem_din     <= '0;
      cpu_dout    <= '0;
      cpu_valid   <= 1'b0;
      rom_loaded  <= 1'b0;
      dl_overrun  <= 1'b0;
      pend_valid  <= 1'b0;
      pend_addr   <= '0;
      pend_ds     <= '0;
      pend_din    <= '0;
      rd_pend     <= 1'b0;
      rd_addr     <= '0;
      cur_addr    <= '0;
      cache_valid <= 1'b0;
      cache_waddr <= '0;
      cache_word  <= '0;
      stale       <= 1'b0;
    end else begin
      wr_d      <= ioctl_wr;
      downl_d   <= ioctl_downl;
      cpu_valid <= 1'b0;

      if (downl_fall) rom_loaded <= 1'b1;
      if (ovr)        dl_overrun <= 1'b1;

      if (push) begin
        pend_valid <= 1'b1;
        pend_addr  <= push_addr;
        pend_ds    <= push_ds;
        pend_din   <= push_din;
      end else if (issue_wr) begin
        pend_valid <= 1'b0;
      end

      if (serve_hit || issue_rd) begin
        rd_pend <= 1'b0;
      end else if (rd_new) begin
        rd_pend <= 1'b1;
        rd_addr <= cpu_addr;
      end

      if (issue_wr) begin
        mem_req  <= ~mem_req;
        mem_we   <= 1'b1;
        mem_addr <= pend_addr;
        mem_ds   <= pend_ds;
        mem_din  <= pend_din;
      end

      if (issue_rd) begin
        mem_req  <= ~mem_req;
        mem_we   <= 1'b0;
        mem_addr <= CPU_BASE + MEM_AW'(rd_addr_sel[15:1]);
        mem_ds   <= 2'b11;
        cur_addr <= rd_addr_sel;
        stale    <= 1'b0;
      end

      if (serve_hit) begin
        cpu_valid <= 1'b1;
        cpu_dout  <= rd_addr_sel[0] ? cache_word[15:8] : cache_word[7:0];
      end

      // A word fetched while a download byte arrived may be outdated, so it
      // is returned but not cached.
      if (rd_done) begin
        cpu_valid   <= 1'b1;
        cpu_dout    <= cur_addr[0] ? mem_dout[15:8] : mem_dout[7:0];
        cache_word  <= mem_dout;
        cache_waddr <= cur_addr[15:1];
        cache_valid <= ~stale & ~capture;
      end

      if (capture) begin
        cache_valid <= 1'b0;
        stale       <= 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_rom_port_arbiter.sv
`timescale 1ns/1ps
`default_nettype none

module tb_rom_port_arbiter;

  localparam logic [21:0] CPU_BASE  = 22'h8;
  localparam logic [24:0] DL_OFFSET = 25'h10;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic        ioctl_downl, ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        cpu_rd;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_dout;
  logic        cpu_valid;
  logic        mem_req, mem_ack, mem_we;
  logic [21:0] mem_addr;
  logic [1:0]  mem_ds;
  logic [15:0] mem_din, mem_dout;
  logic        rom_loaded, dl_overrun;

  always #5 clk_sys = ~clk_sys;

  rom_port_arbiter #(.CPU_BASE(CPU_BASE), .DL_OFFSET(DL_OFFSET)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n),
    .ioctl_downl(ioctl_downl), .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
    .cpu_rd(cpu_rd), .cpu_addr(cpu_addr), .cpu_dout(cpu_dout), .cpu_valid(cpu_valid),
    .mem_req(mem_req), .mem_ack(mem_ack), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_ds(mem_ds), .mem_din(mem_din), .mem_dout(mem_dout),
    .rom_loaded(rom_loaded), .dl_overrun(dl_overrun)
  );

  typedef struct packed {
    logic        we;
    logic [21:0] addr;
    logic [1:0]  ds;
    logic [15:0] din;
  } cmd_t;

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  exp_d;
    bit          exp_hit;
  } rd_vec_t;

  int          checks = 0;
  int          errors = 0;
  int          mem_lat = 2;
  logic [15:0] memw [int];   // SDRAM contents by word address
  logic [7:0]  img  [int];   // intended ROM image by CPU byte address
  cmd_t        cmdq [$];
  int          n_cmds = 0;
  logic        last_req = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // SDRAM model: completes a toggle request after mem_lat idle cycles.
  initial begin
    int cnt;
    int wa;
    logic [15:0] w;
    cnt = 0;
    mem_ack = 1'b0;
    mem_dout = 16'h0;
    forever begin
      @(negedge clk_sys);
      if ($isunknown(mem_req) || mem_req == mem_ack) begin
        cnt = 0;
      end else if (cnt < mem_lat) begin
        cnt++;
      end else begin
        wa = int'(mem_addr);
        if (mem_we) begin
          w = memw.exists(wa) ? memw[wa] : 16'h0;
          if (mem_ds[0]) w[7:0]  = mem_din[7:0];
          if (mem_ds[1]) w[15:8] = mem_din[15:8];
          memw[wa] = w;
        end else begin
          mem_dout = memw.exists(wa) ? memw[wa] : 16'h0;
        end
        mem_ack = mem_req;
        cnt = 0;
      end
    end
  end

  // Command monitor: every mem_req toggle is one issued command.
  always @(negedge clk_sys) begin
    if (reset_n !== 1'b1) begin
      last_req = 1'b0;
    end else if (mem_req !== last_req) begin
      last_req = mem_req;
      cmdq.push_back({mem_we, mem_addr, mem_ds, mem_din});
      n_cmds++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic dl_raw(input logic [24:0] a, input logic [7:0] d);
    ioctl_addr = DL_OFFSET + a;
    ioctl_dout = d;
    ioctl_wr   = 1'b1;
    tick();
    ioctl_wr   = 1'b0;
    tick();
  endtask

  // CPU byte k lives at download byte offset 2*CPU_BASE + k.
  task automatic dl_cpu(input logic [15:0] k, input logic [7:0] d);
    dl_raw(25'({CPU_BASE, 1'b0}) + 25'(k), d);
    img[int'(k)] = d;
  endtask

  task automatic wait_quiet(input string name);
    int stable;
    stable = 0;
    for (int i = 0; i < 300 && stable < 4; i++) begin
      tick();
      stable = (mem_req == mem_ack) ? stable + 1 : 0;
    end
    chk(name, 64'(stable >= 4), 64'd1);
  endtask

  task automatic do_read(input logic [15:0] a, output logic [7:0] d, output int cyc, output int ncmd);
    int c0;
    c0 = n_cmds;
    cyc = 0;
    d = 8'h0;
    cpu_addr = a;
    cpu_rd = 1'b1;
    for (int i = 1; i <= 100; i++) begin
      tick();
      cpu_rd = 1'b0;
      if (cpu_valid) begin
        cyc = i;
        d = cpu_dout;
        break;
      end
    end
    ncmd = n_cmds - c0;
  endtask

  function automatic int rd_class(input int cyc, input int ncmd);
    if (cyc == 1 && ncmd == 0) return 1;
    if (cyc > 1 && ncmd == 1) return 2;
    return 3;
  endfunction

  initial begin
    rd_vec_t     tbl [8];
    logic [7:0]  d;
    int          cyc, ncmd, n0, seen, prev_word, k;
    cmd_t        c;
    logic [7:0]  vq [$];
    int          wl [$];

    tbl[0] = '{16'h0100, 8'hA0, 1'b0};
    tbl[1] = '{16'h0101, 8'hA1, 1'b1};
    tbl[2] = '{16'h0103, 8'hA3, 1'b0};
    tbl[3] = '{16'h0102, 8'hA2, 1'b1};
    tbl[4] = '{16'h0107, 8'hA7, 1'b0};
    tbl[5] = '{16'h0106, 8'hA6, 1'b1};
    tbl[6] = '{16'h0100, 8'hA0, 1'b0};
    tbl[7] = '{16'h0100, 8'hA0, 1'b1};

    reset_n = 1'b0;
    ioctl_downl = 1'b0; ioctl_wr = 1'b0; ioctl_addr = '0; ioctl_dout = '0;
    cpu_rd = 1'b0; cpu_addr = '0;
    repeat (3) tick();
    reset_n = 1'b1;
    tick();
    chk("reset_outputs",
        64'({mem_req, mem_we, mem_addr, mem_ds, mem_din, cpu_dout, cpu_valid, rom_loaded, dl_overrun}), 64'd0);

    // Two download bytes to offsets 0 and 1
    ioctl_downl = 1'b1;
    tick();
    cmdq.delete();
    dl_raw(25'd0, 8'h11);
    dl_raw(25'd1, 8'h22);
    wait_quiet("quiet_dl2");
`ifdef ROM_WRITE_COMBINE_EN
    chk("dl2_ncmd", 64'(cmdq.size()), 64'd1);
    c = '0; if (cmdq.size() > 0) c = cmdq[0];
    chk("dl2_cmd0", 64'(c), 64'({1'b1, 22'h0, 2'b11, 16'h2211}));
`else
    chk("dl2_ncmd", 64'(cmdq.size()), 64'd2);
    c = '0; if (cmdq.size() > 0) c = cmdq[0];
    chk("dl2_cmd0", 64'(c), 64'({1'b1, 22'h0, 2'b01, 16'h1111}));
    c = '0; if (cmdq.size() > 1) c = cmdq[1];
    chk("dl2_cmd1", 64'(c), 64'({1'b1, 22'h0, 2'b10, 16'h2222}));
`endif

    // CPU read while downloading is ignored
    n0 = n_cmds;
    seen = 0;
    cpu_addr = 16'h0002; cpu_rd = 1'b1;
    tick();
    cpu_rd = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (cpu_valid) seen = 1;
      tick();
    end
    chk("rd_in_dl_valid", 64'(seen), 64'd0);
    chk("rd_in_dl_req", 64'(n_cmds - n0), 64'd0);
    chk("rom_loaded_before", 64'(rom_loaded), 64'd0);
    ioctl_downl = 1'b0;
    tick(); tick();
    chk("rom_loaded_after", 64'(rom_loaded), 64'd1);

    // Miss then same-word hit
    memw[int'(CPU_BASE) + 1] = 16'hABCD;
    mem_lat = 5;
    cmdq.delete();
    do_read(16'h0003, d, cyc, ncmd);
    chk("rd3_data", 64'(d), 64'hAB);
    chk("rd3_ncmd", 64'(ncmd), 64'd1);
    c = '0; if (cmdq.size() > 0) c = cmdq[0];
    chk("rd3_cmd", 64'({c.we, c.addr, c.ds}), 64'({1'b0, CPU_BASE + 22'd1, 2'b11}));
    tick();
    chk("rd3_pulse", 64'(cpu_valid), 64'd0);
    do_read(16'h0002, d, cyc, ncmd);
    chk("rd2_data", 64'(d), 64'hCD);
    chk("rd2_hit", 64'(rd_class(cyc, ncmd)), 64'd1);

    // Table-driven reads over a small downloaded image
    mem_lat = 1;
    ioctl_downl = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) begin
      dl_cpu(16'h0100 + 16'(i), 8'hA0 + 8'(i));
      wait_quiet("quiet_tbl_dl");
    end
    ioctl_downl = 1'b0;
    wait_quiet("quiet_tbl_end");
    for (int i = 0; i < 8; i++) begin
      do_read(tbl[i].addr, d, cyc, ncmd);
      chk($sformatf("tbl%0d_data", i), 64'(d), 64'(tbl[i].exp_d));
      chk($sformatf("tbl%0d_kind", i), 64'(rd_class(cyc, ncmd)), tbl[i].exp_hit ? 64'd1 : 64'd2);
    end

    // Randomized download followed by randomized reads
    ioctl_downl = 1'b1;
    tick();
    for (int i = 0; i < 24; i++) begin
      mem_lat = int'($urandom_range(0, 3));
      k = 16'h0200 + int'($urandom_range(0, 63));
      dl_cpu(16'(k), 8'($urandom));
      wl.push_back(k);
      wait_quiet("quiet_rnd_dl");
    end
    ioctl_downl = 1'b0;
    wait_quiet("quiet_rnd_end");
    prev_word = -1;
    for (int i = 0; i < 30; i++) begin
      mem_lat = int'($urandom_range(0, 3));
      k = wl[$urandom_range(0, wl.size() - 1)];
      do_read(16'(k), d, cyc, ncmd);
      chk($sformatf("rnd%0d_data@%0h", i, k), 64'(d), 64'(img[k]));
      chk($sformatf("rnd%0d_kind@%0h", i, k), 64'(rd_class(cyc, ncmd)),
          ((k >> 1) == prev_word) ? 64'd1 : 64'd2);
      prev_word = k >> 1;
    end

    // Read arriving while another is outstanding is served afterwards
    mem_lat = 6;
    cpu_addr = 16'h0100; cpu_rd = 1'b1;
    tick();
    cpu_rd = 1'b0;
    if (cpu_valid) vq.push_back(cpu_dout);
    tick();
    if (cpu_valid) vq.push_back(cpu_dout);
    cpu_addr = 16'h0105; cpu_rd = 1'b1;
    tick();
    cpu_rd = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (cpu_valid) vq.push_back(cpu_dout);
      tick();
    end
    chk("latched_count", 64'(vq.size()), 64'd2);
    chk("latched_first", 64'(vq.size() > 0 ? vq[0] : 8'h00), 64'hA0);
    chk("latched_second", 64'(vq.size() > 1 ? vq[1] : 8'h00), 64'hA5);

    // Overrun: byte edges two cycles apart against a slow memory
    mem_lat = 10;
    ioctl_downl = 1'b1;
    tick();
    dl_raw(25'd1, 8'h01);
    dl_raw(25'd3, 8'h03);
    chk("overrun_2nd", 64'(dl_overrun), 64'd0);
    dl_raw(25'd5, 8'h05);
    chk("overrun_3rd", 64'(dl_overrun), 64'd1);
    wait_quiet("quiet_ovr");
    ioctl_downl = 1'b0;
    tick(); tick();

    // Reset while a read is outstanding
    mem_lat = 20;
    n0 = 0;
    cpu_addr = 16'h0102; cpu_rd = 1'b1;
    tick();
    cpu_rd = 1'b0;
    tick(); tick();
    reset_n = 1'b0;
    tick();
    chk("rst_mid_outputs",
        64'({mem_req, mem_we, mem_addr, mem_ds, mem_din, cpu_dout, cpu_valid, rom_loaded, dl_overrun}), 64'd0);
    reset_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (cpu_valid) seen = 1;
    end
    chk("rst_mid_no_valid", 64'(seen), 64'd0);
    mem_lat = 2;
    do_read(16'h0103, d, cyc, ncmd);
    chk("recover_data", 64'(d), 64'hA3);
    chk("recover_kind", 64'(rd_class(cyc, ncmd)), 64'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
